sccb_init_sequencer: RTL

// - Sequences the SCCB master through the OV7670 power-up register table, then arbitrates SCCB access to the manual camera driver.
// - Sits between the camera driver (manual host) and SCCB (usher/address/subaddress/data/mode/busy).
// - Streams table writes after reset and on restart; the manual host is locked out until the table completes.

---
 rtl/sccb_init_sequencer.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/sccb_init_sequencer.sv
// OV7670 power-up sequencer: streams the register table to the SCCB master, then hands SCCB to the manual host.
// Optional build macro: SCCB_INIT_TIMEOUT_EN adds a busy-rise watchdog with retries and a sticky o_err.
module sccb_init_sequencer #(
    parameter logic [7:0]  DEV_ADDR     = 8'h42,
    parameter logic [1:0]  WRITE_MODE   = 2'b01,
    parameter int unsigned GAP_CYCLES   = 1000,
    parameter int unsigned DELAY_CYCLES = 1000000,
    parameter int unsigned TIMEOUT      = 4096
) (
    input  logic       clk,
    input  logic       reset_,
    input  logic       i_restart,
    input  logic       i_man_usher,
    input  logic [7:0] i_man_address,
    input  logic [7:0] i_man_subaddr,
    input  logic [7:0] i_man_data,
    input  logic [1:0] i_man_mode,
    output logic       o_man_busy,
    output logic       o_usher,
    output logic [7:0] o_address,
    output logic [7:0] o_subaddress,
    output logic [7:0] o_data,
    output logic [1:0] o_mode,
    input  logic       i_busy,
    output logic       o_done,
    output logic       o_err,
    output logic [2:0] o_dbg_state
);

    localparam logic [2:0] ST_LOAD      = 3'd0;
    localparam logic [2:0] ST_ISSUE     = 3'd1;
    localparam logic [2:0] ST_WAIT_ACK  = 3'd2;
    localparam logic [2:0] ST_WAIT_DONE = 3'd3;
    localparam logic [2:0] ST_GAP       = 3'd4;
    localparam logic [2:0] ST_DELAY     = 3'd5;
    localparam logic [2:0] ST_DONE      = 3'd6;

    localparam logic [15:0] ENTRY_END   = 16'hFFFF;
    localparam logic [15:0] ENTRY_DELAY = 16'hFFF0;

    // {subaddr, data}; 16'hFFF0 is a wait marker, 16'hFFFF ends the table.
    function automatic logic [15:0] rom_entry(input logic [7:0] addr);
        case (addr)
            8'd0:    rom_entry = 16'h1280;
            8'd1:    rom_entry = ENTRY_DELAY;
            8'd2:    rom_entry = 16'h1204;
            8'd3:    rom_entry = 16'h1100;
            8'd4:    rom_entry = 16'h0C00;
            8'd5:    rom_entry = 16'h3E00;
            8'd6:    rom_entry = 16'h40D0;
            8'd7:    rom_entry = 16'h3A04;
            8'd8:    rom_entry = 16'h1418;
            8'd9:    rom_entry = 16'h4FB3;
            8'd10:   rom_entry = 16'h50B3;
            8'd11:   rom_entry = 16'h5100;
            8'd12:   rom_entry = 16'h523D;
            8'd13:   rom_entry = 16'h53A7;
            8'd14:   rom_entry = 16'h54E4;
            8'd15:   rom_entry = 16'h589E;
            8'd16:   rom_entry = 16'h3DC0;
            8'd17:   rom_entry = 16'h1713;
            8'd18:   rom_entry = 16'h1801;
            8'd19:   rom_entry = 16'h32B6;
            8'd20:   rom_entry = 16'h1902;
            8'd21:   rom_entry = 16'h1A7A;
            8'd22:   rom_entry = 16'h030A;
            default: rom_entry = ENTRY_END;
        endcase
    endfunction

    // Handshake: o_usher is a one-cycle start, accepted only while i_busy=0; the frame is
    // in flight from the i_busy rise until its fall, and o_* stay stable over that window.
    logic [2:0]  state_q, state_d;
    logic [7:0]  idx_q, idx_d, idx_inc;
    logic [31:0] cnt_q;
    logic [15:0] rom_q;
    logic        usher_q, usher_d;
    logic [7:0]  sub_q, sub_d;
    logic [7:0]  data_q, data_d;
    logic        seq_done;
`ifdef SCCB_INIT_TIMEOUT_EN
    logic [1:0]  retry_q, retry_d;
    logic        err_q, err_d;
`endif

    assign idx_inc = (idx_q == 8'hFF) ? idx_q : idx_q + 8'd1;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        usher_d = 1'b0;
        sub_d   = sub_q;
        data_d  = data_q;
`ifdef SCCB_INIT_TIMEOUT_EN
        retry_d = retry_q;
        err_d   = err_q;
`endif
        case (state_q)
            ST_LOAD: begin
                if (rom_q == ENTRY_END || idx_q == 8'hFF) begin
                    state_d = ST_DONE;
                end else if (rom_q == ENTRY_DELAY) begin
                    state_d = ST_DELAY;
                    idx_d   = idx_inc;
                end else begin
                    state_d = ST_ISSUE;
`ifdef SCCB_INIT_TIMEOUT_EN
                    retry_d = 2'd0;
`endif
                end
            end
            ST_ISSUE: begin
                if (!i_busy) begin
                    usher_d = 1'b1;
                    sub_d   = rom_q[15:8];
                    data_d  = rom_q[7:0];
                    state_d = ST_WAIT_ACK;
                end
            end
            ST_WAIT_ACK: begin
                if (i_busy) begin
                    state_d = ST_WAIT_DONE;
                end
`ifdef SCCB_INIT_TIMEOUT_EN
                else if (cnt_q >= TIMEOUT - 1) begin
                    if (retry_q == 2'd3) begin
                        err_d   = 1'b1;
                        idx_d   = idx_inc;
                        state_d = ST_GAP;
                    end else begin
                        retry_d = retry_q + 2'd1;
                        state_d = ST_ISSUE;
                    end
                end
`endif
            end
            ST_WAIT_DONE: begin
                if (!i_busy) begin
                    idx_d   = idx_inc;
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                if (cnt_q >= GAP_CYCLES - 1) state_d = ST_LOAD;
            end
            ST_DELAY: begin
                if (cnt_q >= DELAY_CYCLES - 1) state_d = ST_LOAD;
            end
            ST_DONE: begin
                if (i_restart) begin
                    idx_d   = 8'd0;
                    state_d = ST_LOAD;
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    // The ROM is addressed by idx_d so rom_q always holds entry[idx_q], even right after a restart.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_q <= ST_LOAD;
            idx_q   <= 8'd0;
            cnt_q   <= 32'd0;
            rom_q   <= rom_entry(8'd0);
            usher_q <= 1'b0;
            sub_q   <= 8'd0;
            data_q  <= 8'd0;
`ifdef SCCB_INIT_TIMEOUT_EN
            retry_q <= 2'd0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= (state_d != state_q) ? 32'd0 : cnt_q + 32'd1;
            rom_q   <= rom_entry(idx_d);
            usher_q <= usher_d;
            sub_q   <= sub_d;
            data_q  <= data_d;
`ifdef SCCB_INIT_TIMEOUT_EN
            retry_q <= retry_d;
            err_q   <= err_d;
`endif
        end
    end

    assign seq_done     = (state_q == ST_DONE);
    assign o_done       = seq_done;
    assign o_usher      = seq_done ? i_man_usher   : usher_q;
    assign o_address    = seq_done ? i_man_address : DEV_ADDR;
    assign o_subaddress = seq_done ? i_man_subaddr : sub_q;
    assign o_data       = seq_done ? i_man_data    : data_q;
    assign o_mode       = seq_done ? i_man_mode    : WRITE_MODE;
    assign o_man_busy   = seq_done ? i_busy        : 1'b1;
    assign o_dbg_state  = state_q;

`ifdef SCCB_INIT_TIMEOUT_EN
    assign o_err = err_q;
`else
    assign o_err = 1'b0;
    // TIMEOUT has no effect without the watchdog; this empty block only references it.
    if (TIMEOUT == 0) begin : g_timeout_unused
    end
`endif

endmodule
